// File: rtl/sram_controller.sv
// Word-wide CPU access to a 16-bit asynchronous SRAM, split into low/high half accesses.
// ready stalls the pipeline until the second half completes.
module sram_controller #(
   parameter int unsigned SRAM_WAIT = 1,
   parameter logic [31:0] ADDR_BASE = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned WORD_W = 17;
   localparam int unsigned HALF_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                last_c;
   logic [WORD_W-1:0]   word_c;
   logic                half_c;
   logic                dq_oe;
   logic [HALF_W-1:0]   dq_out;
   logic                cap_lo_c;
   logic                cap_hi_c;

   assign last_c = (cnt == CNT_W'(SRAM_WAIT));
   assign word_c = WORD_W'((address - ADDR_BASE) >> 2);

   // State register; the dwell counter restarts on every state change
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: each data state dwells SRAM_WAIT+1 cycles
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (wr_en)      state_nxt = WR_LO;
            else if (rd_en) state_nxt = RD_LO;
         end
         RD_LO: begin
            if (last_c) state_nxt = RD_HI;
            else        cnt_nxt   = cnt + CNT_W'(1);
         end
         RD_HI: begin
            if (last_c) state_nxt = DONE;
            else        cnt_nxt   = cnt + CNT_W'(1);
         end
         WR_LO: begin
            if (last_c) state_nxt = WR_HI;
            else        cnt_nxt   = cnt + CNT_W'(1);
         end
         WR_HI: begin
            if (last_c) state_nxt = DONE;
            else        cnt_nxt   = cnt + CNT_W'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = write_data[15:0];
      half_c    = 1'b0;
      cap_lo_c  = 1'b0;
      cap_hi_c  = 1'b0;
      case (state)
         RD_LO: cap_lo_c = last_c;
         RD_HI: begin
            half_c   = 1'b1;
            cap_hi_c = last_c;
         end
         WR_LO: begin
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
         end
         WR_HI: begin
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
            dq_out    = write_data[31:16];
            half_c    = 1'b1;
         end
         default: ;
      endcase
   end

   // Read capture: each half is latched on the last cycle of its dwell
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else begin
         if (cap_lo_c) read_data[15:0]  <= SRAM_DQ;
         if (cap_hi_c) read_data[31:16] <= SRAM_DQ;
      end
   end

   assign ready     = (state == DONE) | ((state == IDLE) & ~wr_en & ~rd_en);
   assign SRAM_ADDR = {word_c, half_c};
   assign SRAM_DQ   = dq_oe ? dq_out : {HALF_W{1'bz}};
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        we_n, oe_n, ce_n, ub_n, lb_n;

   logic        sw_rd;
   logic [31:0] rd0, rd3;
   logic        rdy0, rdy3;
   wire  [15:0] dq0, dq3;
   logic [17:0] sa0, sa3;
   logic        we0, oe0, ce0, ub0, lb0, we3, oe3, ce3, ub3, lb3;

   logic        model_drive;
   logic        pre_en;
   logic [3:0]  pre_addr;
   logic [15:0] pre_data;
   logic [15:0] mem [0:15];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_controller #(.SRAM_WAIT(1), .ADDR_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
      .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n));

   sram_controller #(.SRAM_WAIT(0), .ADDR_BASE(32'd1024)) dut_w0 (
      .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(sw_rd), .address(32'd1024),
      .write_data(32'd0), .read_data(rd0), .ready(rdy0),
      .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0),
      .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0));

   sram_controller #(.SRAM_WAIT(3), .ADDR_BASE(32'd1024)) dut_w3 (
      .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(sw_rd), .address(32'd1024),
      .write_data(32'd0), .read_data(rd3), .ready(rdy3),
      .SRAM_DQ(dq3), .SRAM_ADDR(sa3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
      .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3));

   // SRAM model: drives the bus when not being written, latches on WE_N low
   assign sram_dq = (model_drive && we_n) ? mem[sram_addr[3:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (pre_en)     mem[pre_addr] <= pre_data;
      else if (!we_n) mem[sram_addr[3:0]] <= sram_dq;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      step();
      pre_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data got %h exp 00000000", read_data); end
      n_checks++;
      if (we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got %b exp 1", we_n); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
      n_checks++;
      if (dut.dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe got %b exp 0", dut.dq_oe); end
      n_checks++;
      if ({ce_n, oe_n, ub_n, lb_n} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0000", {ce_n, oe_n, ub_n, lb_n}); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_write();
      logic [17:0] exp_a;
      address = 32'd1024; write_data = 32'hDEADBEEF; wr_en = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL write_ready_c0 got %b exp 0", ready); end
      for (int k = 1; k <= 5; k++) begin
         step();
         n_checks++;
         if (ready !== (k == 5)) begin n_fail++; $display("FAIL write_ready_c%0d got %b exp %b", k, ready, k == 5); end
         if (k <= 4) begin
            exp_a = (k <= 2) ? 18'd0 : 18'd1;
            n_checks++;
            if (we_n !== 1'b0) begin n_fail++; $display("FAIL write_we_n_c%0d got %b exp 0", k, we_n); end
            n_checks++;
            if (sram_addr !== exp_a) begin n_fail++; $display("FAIL write_addr_c%0d got %0d exp %0d", k, sram_addr, exp_a); end
         end
      end
      n_checks++;
      if (we_n !== 1'b1) begin n_fail++; $display("FAIL write_we_n_done got %b exp 1", we_n); end
      wr_en = 1'b0;
      step();
      n_checks++;
      if (mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL write_mem0 got %h exp BEEF", mem[0]); end
      n_checks++;
      if (mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL write_mem1 got %h exp DEAD", mem[1]); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL write_ready_idle got %b exp 1", ready); end
   endtask

   task automatic test_read();
      preload(4'd2, 16'h1234);
      preload(4'd3, 16'h5678);
      address = 32'd1028; rd_en = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL read_ready_c0 got %b exp 0", ready); end
      for (int k = 1; k <= 5; k++) begin
         step();
         n_checks++;
         if (ready !== (k == 5)) begin n_fail++; $display("FAIL read_ready_c%0d got %b exp %b", k, ready, k == 5); end
         n_checks++;
         if (we_n !== 1'b1) begin n_fail++; $display("FAIL read_we_n_c%0d got %b exp 1", k, we_n); end
      end
      n_checks++;
      if (read_data !== 32'h56781234) begin n_fail++; $display("FAIL read_data got %h exp 56781234", read_data); end
      rd_en = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      int lows = 0;
      address = 32'd1032; write_data = 32'hA5A55A5A; rd_en = 1'b1; wr_en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (we_n === 1'b0) lows++;
      end
      n_checks++;
      if (lows != 4) begin n_fail++; $display("FAIL simul_we_cycles got %0d exp 4", lows); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_c5 got %b exp 1", ready); end
      n_checks++;
      if (read_data !== 32'h56781234) begin n_fail++; $display("FAIL simul_read_data got %h exp 56781234", read_data); end
      rd_en = 1'b0; wr_en = 1'b0;
      step();
      n_checks++;
      if ({mem[5], mem[4]} !== 32'hA5A55A5A) begin n_fail++; $display("FAIL simul_mem got %h exp A5A55A5A", {mem[5], mem[4]}); end
   endtask

   task automatic test_back_to_back();
      address = 32'd1028; rd_en = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         step();
         n_checks++;
         if (ready !== (k == 5 || k == 11)) begin n_fail++; $display("FAIL b2b_ready_c%0d got %b exp %b", k, ready, (k == 5 || k == 11)); end
      end
      rd_en = 1'b0;
      step();
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle got %b exp 1", ready); end
   endtask

   task automatic test_dropped();
      preload(4'd2, 16'hCAFE);
      preload(4'd3, 16'hBABE);
      address = 32'd1028; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready_c1 got %b exp 0", ready); end
      for (int k = 2; k <= 6; k++) begin
         step();
         n_checks++;
         if (ready !== (k >= 5)) begin n_fail++; $display("FAIL drop_ready_c%0d got %b exp %b", k, ready, k >= 5); end
      end
      n_checks++;
      if (read_data !== 32'hBABECAFE) begin n_fail++; $display("FAIL drop_read_data got %h exp BABECAFE", read_data); end
   endtask

   task automatic test_reset_mid();
      address = 32'd1024; write_data = 32'h11112222; wr_en = 1'b1;
      for (int k = 1; k <= 4; k++) step();
      n_checks++;
      if (we_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_pre got %b exp 0", we_n); end
      rst = 1'b1; wr_en = 1'b0;
      step();
      n_checks++;
      if (we_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_n got %b exp 1", we_n); end
      n_checks++;
      if (dut.dq_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_dq_oe got %b exp 0", dut.dq_oe); end
      n_checks++;
      if (read_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_read_data got %h exp 00000000", read_data); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", ready); end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (we_n !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_%0d got we_n=%b ready=%b exp 1 1", k, we_n, ready); end
      end
   endtask

   task automatic test_idle();
      address = 32'd1036;
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++;
         if (ready !== 1'b1 || we_n !== 1'b1 || dut.dq_oe !== 1'b0 || sram_addr !== 18'd6) begin
            n_fail++;
            $display("FAIL idle_%0d got ready=%b we_n=%b oe=%b addr=%0d exp 1 1 0 6", k, ready, we_n, dut.dq_oe, sram_addr);
         end
      end
   endtask

   task automatic test_sweep();
      sw_rd = 1'b1;
      #1;
      n_checks++;
      if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin n_fail++; $display("FAIL sweep_c0 got %b%b exp 00", rdy0, rdy3); end
      for (int k = 1; k <= 10; k++) begin
         step();
         sw_rd = 1'b0;
         #1;
         n_checks++;
         if (rdy0 !== (k >= 3)) begin n_fail++; $display("FAIL sweep_w0_c%0d got %b exp %b", k, rdy0, k >= 3); end
         n_checks++;
         if (rdy3 !== (k >= 9)) begin n_fail++; $display("FAIL sweep_w3_c%0d got %b exp %b", k, rdy3, k >= 9); end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; sw_rd = 1'b0;
      address = 32'd1024; write_data = 32'd0;
      model_drive = 1'b1; pre_en = 1'b0; pre_addr = 4'd0; pre_data = 16'd0;
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_back_to_back();
      test_dropped();
      test_reset_mid();
      test_idle();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
